// File: rtl/sfsm_pkg.sv
// Shared definitions for the table-driven secure FSM engine: config table
// selectors, per-edge action codes, and bit-count / saturating-add helpers.
package sfsm_pkg;

  localparam logic [1:0] CFG_NXT = 2'd0;
  localparam logic [1:0] CFG_OUT = 2'd1;
  localparam logic [1:0] CFG_ENC = 2'd2;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_RESTART = 2'd1,
    ACT_RECOVER = 2'd2,
    ACT_STEP    = 2'd3
  } act_e;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // One extra bit on the sum so a + b can never wrap before the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/sfsm_code_decoder.sv
// Reverse lookup of a state code against the encoding table. Lowest matching
// index wins so duplicate codes resolve deterministically.
module sfsm_code_decoder #(
  parameter  int NSTATE = 27,
  parameter  int ENC_W  = 5,
  localparam int IDX_W  = $clog2(NSTATE)
) (
  input  logic [ENC_W-1:0]        code_i,
  input  logic [NSTATE*ENC_W-1:0] enc_flat_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    valid_o
);

  // Scan from the top down so the last assignment is the lowest matching index.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NSTATE - 1; i >= 0; i--) begin
      if (enc_flat_i[i*ENC_W +: ENC_W] == code_i) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfsm_prog_engine.sv
// Programmable Moore FSM engine: run-time loaded next-state, output and
// encoding tables, illegal-code detection with safe recovery, and a
// saturating Hamming-distance accumulator on the state register.
//
// action      | meaning
// ------------+---------------------------------------------------------
// ACT_RESTART | reload enc/out of the reset state, clear alarm and hd_acc
// ACT_RECOVER | illegal code, alarm set, or bad target: force reset code,
//             | safe output 0, latch alarm, hd_acc untouched
// ACT_STEP    | legal transition to nxt[cur][ptext], accumulate bit flips
// ACT_HOLD    | no change
module sfsm_prog_engine
  import sfsm_pkg::*;
#(
  parameter  int IN_W      = 2,
  parameter  int OUT_W     = 3,
  parameter  int NSTATE    = 27,
  parameter  int ENC_W     = 5,
  parameter  int RESET_IDX = 0,
  parameter  int HD_W      = 16,
  localparam int IDX_W     = $clog2(NSTATE),
  localparam int CFG_AW    = IDX_W + IN_W,
  localparam int DAT_W     = (IDX_W > OUT_W) ? ((IDX_W > ENC_W) ? IDX_W : ENC_W)
                                             : ((OUT_W > ENC_W) ? OUT_W : ENC_W)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              run,
  input  logic              restart,
  input  logic [IN_W-1:0]   ptext,
  output logic [OUT_W-1:0]  rtext,
  output logic [ENC_W-1:0]  state_q,
  output logic              alarm,
  output logic [HD_W-1:0]   hd_acc,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [DAT_W-1:0]  cfg_wdata,
  output logic              cfg_err
);

  if (ENC_W < IDX_W) begin : g_enc_w_chk
    $error("sfsm_prog_engine: ENC_W must be at least $clog2(NSTATE)");
  end

  localparam logic [IDX_W-1:0] RST_I  = IDX_W'(RESET_IDX);
  localparam logic [31:0]      HD_MAX = (HD_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << HD_W) - 32'd1);

  logic [IDX_W-1:0] nxt_q [NSTATE][2**IN_W];
  logic [OUT_W-1:0] out_q [NSTATE];
  logic [ENC_W-1:0] enc_q [NSTATE];

  logic [NSTATE*ENC_W-1:0] enc_flat;
  logic [IDX_W-1:0]        cur_idx;
  logic                    code_ok;
  logic [IDX_W-1:0]        nxt_j;
  logic                    j_ok;
  logic [IDX_W-1:0]        j_sel;
  logic [ENC_W-1:0]        enc_j;
  logic [31:0]             hd_sum;
  act_e                    act;

  logic [IDX_W-1:0] addr_state;
  logic [IN_W-1:0]  addr_sym;
  logic             addr_ok;
  logic             wr_ok;

  // Flatten the encoding table for the reverse-lookup decoder.
  always_comb begin
    enc_flat = '0;
    for (int i = 0; i < NSTATE; i++) begin
      enc_flat[i*ENC_W +: ENC_W] = enc_q[i];
    end
  end

  sfsm_code_decoder #(
    .NSTATE (NSTATE),
    .ENC_W  (ENC_W)
  ) u_dec (
    .code_i     (state_q),
    .enc_flat_i (enc_flat),
    .idx_o      (cur_idx),
    .valid_o    (code_ok)
  );

  // A target index beyond NSTATE is a fault; j_sel keeps table reads in range.
  assign nxt_j  = nxt_q[cur_idx][ptext];
  assign j_ok   = (int'(nxt_j) < NSTATE);
  assign j_sel  = j_ok ? nxt_j : RST_I;
  assign enc_j  = enc_q[j_sel];
  assign hd_sum = sat_add(32'(hd_acc), popcount(32'(state_q ^ enc_j)), HD_MAX);

  // Per-edge action in priority order: restart, recovery, step, hold.
  always_comb begin
    act = ACT_HOLD;
    if (restart) begin
      act = ACT_RESTART;
    end else if (!code_ok || alarm) begin
      act = ACT_RECOVER;
    end else if (run) begin
      act = j_ok ? ACT_STEP : ACT_RECOVER;
    end
  end

  // Engine state register and registered Moore outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ENC_W'(RESET_IDX);
      rtext   <= '0;
      alarm   <= 1'b0;
      hd_acc  <= '0;
    end else begin
      case (act)
        ACT_RESTART: begin
          state_q <= enc_q[RST_I];
          rtext   <= out_q[RST_I];
          alarm   <= 1'b0;
          hd_acc  <= '0;
        end
        ACT_RECOVER: begin
          state_q <= enc_q[RST_I];
          rtext   <= '0;
          alarm   <= 1'b1;
        end
        ACT_STEP: begin
          state_q <= enc_j;
          rtext   <= out_q[j_sel];
          hd_acc  <= hd_sum[HD_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign addr_state = cfg_addr[CFG_AW-1:IN_W];
  assign addr_sym   = cfg_addr[IN_W-1:0];

  // Address range check per target table; the reserved selector never matches.
  always_comb begin
    addr_ok = 1'b0;
    case (cfg_sel)
      CFG_NXT:          addr_ok = (int'(addr_state) < NSTATE);
      CFG_OUT, CFG_ENC: addr_ok = (int'(cfg_addr) < NSTATE);
      default:          addr_ok = 1'b0;
    endcase
  end

  // Tables are only writable while the engine is stopped.
  assign wr_ok = cfg_we && !run && addr_ok;

  // Configuration tables and the rejected-write pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NSTATE; i++) begin
        for (int s = 0; s < 2**IN_W; s++) begin
          nxt_q[i][s] <= IDX_W'(i);
        end
        out_q[i] <= '0;
        enc_q[i] <= ENC_W'(i);
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      if (wr_ok) begin
        case (cfg_sel)
          CFG_NXT: nxt_q[addr_state][addr_sym]   <= cfg_wdata[IDX_W-1:0];
          CFG_OUT: out_q[cfg_addr[IDX_W-1:0]]    <= cfg_wdata[OUT_W-1:0];
          CFG_ENC: enc_q[cfg_addr[IDX_W-1:0]]    <= cfg_wdata[ENC_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule
